// File: rtl/sweep_pkg.sv
// -----------------------------------------------------------------------------
// sweep_pkg
// Shared types and helpers for the phase increment sweeper.
//   sweep_state_t : sweep FSM states (RUN_DN exists only with SWEEP_TRIANGLE_EN)
//   REG_*         : config register selects carried on cfg_addr[3:2]
//   byte_merge    : replaces one byte lane of a 32-bit word
// Optional feature macro: SWEEP_TRIANGLE_EN (adds the down-sweep state).
// -----------------------------------------------------------------------------
package sweep_pkg;

`ifdef SWEEP_TRIANGLE_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    RUN_DN = 2'd2,
    DONE   = 2'd3
  } sweep_state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd3
  } sweep_state_t;
`endif

  localparam logic [1:0] REG_START = 2'd0;
  localparam logic [1:0] REG_STEP  = 2'd1;
  localparam logic [1:0] REG_STOP  = 2'd2;
  localparam logic [1:0] REG_DWELL = 2'd3;

  // Callers truncate the result to their register width, which is how byte
  // lanes beyond that width get dropped.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [7:0]  data,
                                             input logic [1:0]  lane);
    logic [31:0] mask;
    mask = 32'h0000_00FF << {lane, 3'b000};
    return (old_val & ~mask) | ({4{data}} & mask);
  endfunction

endpackage

// File: rtl/sweep_dwell_timer.sv
// -----------------------------------------------------------------------------
// sweep_dwell_timer
// Down-counter that times how long each increment value is held.
//   clk, rst          : clock, asynchronous active-high reset
//   load_i            : (re)load the counter from load_value_i
//   load_value_i      : dwell length in cycles; 0 is treated as 1
//   enable_i          : count while high
//   expire_o          : high during the last cycle of the dwell
// -----------------------------------------------------------------------------
module sweep_dwell_timer #(
  parameter int DWELL_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_i,
  input  logic [DWELL_WIDTH-1:0] load_value_i,
  input  logic                   enable_i,
  output logic                   expire_o
);

  localparam logic [DWELL_WIDTH-1:0] ONE = DWELL_WIDTH'(1);

  logic [DWELL_WIDTH-1:0] cnt_q;

  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= (load_value_i == '0) ? ONE : load_value_i;
    end else if (enable_i && (cnt_q > ONE)) begin
      cnt_q <= cnt_q - ONE;
    end
  end

  // Counter parks at 1 so the expiry condition is simply "count == 1".
  assign expire_o = enable_i && (cnt_q == ONE);

endmodule

// File: rtl/phase_inc_sweeper.sv
// -----------------------------------------------------------------------------
// phase_inc_sweeper
// Generates the phase accumulator's add_value as a programmable linear chirp.
// Byte-written shadow config (start/step/stop/dwell) is copied to the active
// set on cmd_start; each increment is held for max(dwell,1) cycles and then
// stepped toward stop, once or in a loop.
//   clk, rst   : clock, asynchronous active-high reset
//   cfg_data   : write data byte
//   cfg_addr   : [3:2] register select, [1:0] byte lane (0 = LSB)
//   cfg_we     : byte write strobe
//   cfg_loop   : restart at start after reaching stop (latched on cmd_start)
//   cfg_tri    : triangle mode (latched on cmd_start, SWEEP_TRIANGLE_EN only)
//   cmd_start  : latch config and (re)start the sweep
//   cmd_abort  : return to IDLE; wins over cmd_start
//   add_value  : phase increment (0 in IDLE)
//   busy       : high while sweeping
//   done       : one-cycle pulse at each end of sweep
// Optional feature macro: SWEEP_TRIANGLE_EN (down-sweep back to start).
// -----------------------------------------------------------------------------
module phase_inc_sweeper
  import sweep_pkg::*;
#(
  parameter int INC_WIDTH   = 16,
  parameter int DWELL_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           cfg_data,
  input  logic [3:0]           cfg_addr,
  input  logic                 cfg_we,
  input  logic                 cfg_loop,
  input  logic                 cfg_tri,
  input  logic                 cmd_start,
  input  logic                 cmd_abort,
  output logic [INC_WIDTH-1:0] add_value,
  output logic                 busy,
  output logic                 done
);

  // Shadow (host-written) and active (running) configuration.
  logic [INC_WIDTH-1:0]   start_sh_q, step_sh_q, stop_sh_q;
  logic [DWELL_WIDTH-1:0] dwell_sh_q;
  logic [INC_WIDTH-1:0]   start_q, step_q, stop_q;
  logic [DWELL_WIDTH-1:0] dwell_q;
  logic                   loop_q;

  sweep_state_t         state_q;
  logic [INC_WIDTH-1:0] cur_q;
  logic                 busy_q, done_q;

  // Next-value datapath.
  logic                   start_go, running, at_stop;
  logic                   tmr_load, expire;
  logic [DWELL_WIDTH-1:0] tmr_value;
  logic [INC_WIDTH:0]     sum_up;
  logic [INC_WIDTH-1:0]   up_next;
  logic [INC_WIDTH-1:0]   start_wr, step_wr, stop_wr;
  logic [DWELL_WIDTH-1:0] dwell_wr;

`ifdef SWEEP_TRIANGLE_EN
  logic                 tri_q;
  logic                 at_start;
  logic [INC_WIDTH:0]   diff_dn;
  logic [INC_WIDTH-1:0] dn_next;
`else
  logic unused_tri;
  assign unused_tri = cfg_tri;
`endif

  // NOTE: every signal gets a default at the top of always_comb; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    start_go  = cmd_start && !cmd_abort;
    running   = (state_q == RUN);
`ifdef SWEEP_TRIANGLE_EN
    if (state_q == RUN_DN) running = 1'b1;
`endif
    tmr_load  = start_go || (running && expire);
    tmr_value = start_go ? dwell_sh_q : dwell_q;

    // One extra bit keeps the sum from wrapping; any overshoot clamps to stop.
    sum_up  = {1'b0, cur_q} + {1'b0, step_q};
    up_next = (sum_up >= {1'b0, stop_q}) ? stop_q : sum_up[INC_WIDTH-1:0];
    at_stop = (cur_q >= stop_q);

`ifdef SWEEP_TRIANGLE_EN
    // Borrow in the top bit flags underflow; either way clamp to start.
    diff_dn  = {1'b0, cur_q} - {1'b0, step_q};
    dn_next  = (diff_dn[INC_WIDTH] || (diff_dn[INC_WIDTH-1:0] < start_q))
             ? start_q : diff_dn[INC_WIDTH-1:0];
    at_start = (cur_q <= start_q);
`endif

    start_wr = INC_WIDTH'(byte_merge(32'(start_sh_q), cfg_data, cfg_addr[1:0]));
    step_wr  = INC_WIDTH'(byte_merge(32'(step_sh_q),  cfg_data, cfg_addr[1:0]));
    stop_wr  = INC_WIDTH'(byte_merge(32'(stop_sh_q),  cfg_data, cfg_addr[1:0]));
    dwell_wr = DWELL_WIDTH'(byte_merge(32'(dwell_sh_q), cfg_data, cfg_addr[1:0]));
  end

  sweep_dwell_timer #(
    .DWELL_WIDTH (DWELL_WIDTH)
  ) u_dwell (
    .clk          (clk),
    .rst          (rst),
    .load_i       (tmr_load),
    .load_value_i (tmr_value),
    .enable_i     (running),
    .expire_o     (expire)
  );

  // NOTE: the config registers are a handful of flops, not a RAM, so they are
  // reset; a fresh sweep after reset must see all-zero settings.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_sh_q <= '0;
      step_sh_q  <= '0;
      stop_sh_q  <= '0;
      dwell_sh_q <= '0;
      start_q    <= '0;
      step_q     <= '0;
      stop_q     <= '0;
      dwell_q    <= '0;
      loop_q     <= 1'b0;
`ifdef SWEEP_TRIANGLE_EN
      tri_q      <= 1'b0;
`endif
      state_q    <= IDLE;
      cur_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      // Shadow writes are independent of the sweep FSM.
      if (cfg_we) begin
        unique case (cfg_addr[3:2])
          REG_START: start_sh_q <= start_wr;
          REG_STEP:  step_sh_q  <= step_wr;
          REG_STOP:  stop_sh_q  <= stop_wr;
          REG_DWELL: dwell_sh_q <= dwell_wr;
          default: ;
        endcase
      end

      if (cmd_abort) begin
        state_q <= IDLE;
        cur_q   <= '0;        // add_value is 0 whenever IDLE
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
      end else if (cmd_start) begin
        // Shadow values before any same-cycle write are what get latched.
        start_q <= start_sh_q;
        step_q  <= step_sh_q;
        stop_q  <= stop_sh_q;
        dwell_q <= dwell_sh_q;
        loop_q  <= cfg_loop;
`ifdef SWEEP_TRIANGLE_EN
        tri_q   <= cfg_tri;
`endif
        cur_q   <= start_sh_q;
        state_q <= RUN;
        busy_q  <= 1'b1;
        done_q  <= 1'b0;
      end else begin
        done_q <= 1'b0;
        unique case (state_q)
          RUN: begin
            if (expire) begin
              if (at_stop) begin
`ifdef SWEEP_TRIANGLE_EN
                if (tri_q) begin
                  state_q <= RUN_DN;
                  cur_q   <= dn_next;
                end else
`endif
                begin
                  done_q <= 1'b1;
                  if (loop_q) begin
                    cur_q <= start_q;
                  end else begin
                    state_q <= DONE;
                    busy_q  <= 1'b0;
                  end
                end
              end else begin
                cur_q <= up_next;
              end
            end
          end
`ifdef SWEEP_TRIANGLE_EN
          RUN_DN: begin
            if (expire) begin
              if (at_start) begin
                done_q <= 1'b1;
                cur_q  <= start_q;
                if (loop_q) begin
                  state_q <= RUN;
                end else begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                end
              end else begin
                cur_q <= dn_next;
              end
            end
          end
`endif
          default: ;  // IDLE and DONE hold until a command arrives
        endcase
      end
    end
  end

  assign add_value = cur_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_phase_inc_sweeper.sv
// -----------------------------------------------------------------------------
// tb_phase_inc_sweeper
// Directed bench for phase_inc_sweeper (INC_WIDTH = DWELL_WIDTH = 16).
// Inputs change 1 time unit after the rising edge; outputs are compared at the
// same point, i.e. k cycles after cmd_start is sampled is "cycle k".
// -----------------------------------------------------------------------------
module tb_phase_inc_sweeper;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  cfg_data;
  logic [3:0]  cfg_addr;
  logic        cfg_we, cfg_loop, cfg_tri, cmd_start, cmd_abort;
  logic [15:0] add_value;
  logic        busy, done;

  localparam logic [1:0] SEL_START = 2'd0;
  localparam logic [1:0] SEL_STEP  = 2'd1;
  localparam logic [1:0] SEL_STOP  = 2'd2;
  localparam logic [1:0] SEL_DWELL = 2'd3;

  phase_inc_sweeper #(
    .INC_WIDTH   (16),
    .DWELL_WIDTH (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_data  (cfg_data),
    .cfg_addr  (cfg_addr),
    .cfg_we    (cfg_we),
    .cfg_loop  (cfg_loop),
    .cfg_tri   (cfg_tri),
    .cmd_start (cmd_start),
    .cmd_abort (cmd_abort),
    .add_value (add_value),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] add;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic check_out(input string tag, input logic [15:0] a, input logic b, input logic d);
    check({tag, " add_value"}, 32'(add_value), 32'(a));
    check({tag, " busy"},      32'(busy),      32'(b));
    check({tag, " done"},      32'(done),      32'(d));
  endtask

  task automatic step_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [15:0] a, input logic b, input logic d);
    vec_t v;
    v.add  = a;
    v.busy = b;
    v.done = d;
    exp_q.push_back(v);
  endtask

  // Compare the current cycle against each record, advancing one cycle each.
  task automatic run_table(input string tag);
    for (int i = 0; i < exp_q.size(); i++) begin
      check_out($sformatf("%s[%0d]", tag, i), exp_q[i].add, exp_q[i].busy, exp_q[i].done);
      step_n(1);
    end
    exp_q.delete();
  endtask

  // All four byte lanes are written; lanes 2/3 must be dropped at 16 bits.
  task automatic write_reg(input logic [1:0] sel, input logic [31:0] val);
    for (int lane = 0; lane < 4; lane++) begin
      cfg_we   = 1'b1;
      cfg_addr = {sel, 2'(lane)};
      cfg_data = val[8*lane +: 8];
      step_n(1);
    end
    cfg_we = 1'b0;
  endtask

  task automatic write_cfg(input logic [31:0] s, input logic [31:0] st,
                           input logic [31:0] sp, input logic [31:0] dw);
    write_reg(SEL_START, s);
    write_reg(SEL_STEP,  st);
    write_reg(SEL_STOP,  sp);
    write_reg(SEL_DWELL, dw);
  endtask

  task automatic pulse_start();
    cmd_start = 1'b1;
    step_n(1);
    cmd_start = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    cfg_data = '0; cfg_addr = '0; cfg_we = 1'b0;
    cfg_loop = 1'b0; cfg_tri = 1'b0; cmd_start = 1'b0; cmd_abort = 1'b0;
    #1;
    check_out("reset", 16'h0000, 1'b0, 1'b0);
    step_n(2);
    rst = 1'b0;
    step_n(1);
    check_out("idle", 16'h0000, 1'b0, 1'b0);

    // One-shot sawtooth: 0x10..0x28 by 8, 3 cycles per value.
    write_cfg(32'h10, 32'h08, 32'h28, 32'd3);
    pulse_start();
    for (int k = 0; k < 12; k++) push(16'h0010 + 16'(8 * (k / 3)), 1'b1, 1'b0);
    push(16'h0028, 1'b0, 1'b1);
    push(16'h0028, 1'b0, 1'b0);
    push(16'h0028, 1'b0, 1'b0);
    run_table("oneshot");

    // Overflowing step clamps to stop; dwell 0 acts as 1.
    write_cfg(32'hFFF0, 32'h20, 32'hFFFF, 32'd0);
    pulse_start();
    push(16'hFFF0, 1'b1, 1'b0);
    push(16'hFFFF, 1'b1, 1'b0);
    push(16'hFFFF, 1'b0, 1'b1);
    push(16'hFFFF, 1'b0, 1'b0);
    run_table("clamp");

    // Loop mode; stop rewritten mid-sweep must not affect the running sweep.
    write_cfg(32'h10, 32'h08, 32'h28, 32'd3);
    cfg_loop = 1'b1;
    pulse_start();                          // cycle 0
    write_reg(SEL_STOP, 32'hABCD_0030);     // cycles 0..3, now at cycle 4
    step_n(7);
    check_out("loop k11", 16'h0028, 1'b1, 1'b0);
    step_n(1);
    check_out("loop wrap1", 16'h0010, 1'b1, 1'b1);
    step_n(1);
    check_out("loop k13", 16'h0010, 1'b1, 1'b0);
    step_n(10);
    check_out("loop k23", 16'h0028, 1'b1, 1'b0);
    step_n(1);
    check_out("loop wrap2", 16'h0010, 1'b1, 1'b1);

    // Restart in RUN picks up the new stop (upper lanes ignored).
    pulse_start();
    check_out("restart k0", 16'h0010, 1'b1, 1'b0);
    step_n(12);
    check_out("newstop k12", 16'h0030, 1'b1, 1'b0);
    step_n(3);
    check_out("newstop wrap", 16'h0010, 1'b1, 1'b1);

    // Abort beats a simultaneous start.
    cmd_start = 1'b1;
    cmd_abort = 1'b1;
    step_n(1);
    cmd_start = 1'b0;
    cmd_abort = 1'b0;
    check_out("start+abort", 16'h0000, 1'b0, 1'b0);
    pulse_start();
    check_out("start after abort", 16'h0010, 1'b1, 1'b0);
    cmd_abort = 1'b1;
    step_n(1);
    cmd_abort = 1'b0;
    check_out("abort", 16'h0000, 1'b0, 1'b0);

    // step = 0 below stop: start held forever, no done.
    write_reg(SEL_STEP, 32'h0);
    cfg_loop = 1'b0;
    pulse_start();
    step_n(20);
    check_out("step0", 16'h0010, 1'b1, 1'b0);
    cmd_abort = 1'b1;
    step_n(1);
    cmd_abort = 1'b0;

    // Triangle request: 4,6,8 then back down only when the feature is built in.
    write_cfg(32'd4, 32'd2, 32'd8, 32'd1);
    cfg_tri = 1'b1;
    pulse_start();
    push(16'd4, 1'b1, 1'b0);
    push(16'd6, 1'b1, 1'b0);
    push(16'd8, 1'b1, 1'b0);
`ifdef SWEEP_TRIANGLE_EN
    push(16'd6, 1'b1, 1'b0);
    push(16'd4, 1'b1, 1'b0);
    push(16'd4, 1'b0, 1'b1);
    push(16'd4, 1'b0, 1'b0);
`else
    push(16'd8, 1'b0, 1'b1);
    push(16'd8, 1'b0, 1'b0);
`endif
    run_table("tri");
    cfg_tri = 1'b0;

    // Asynchronous reset mid-RUN clears outputs at once and all config.
    pulse_start();
    check_out("pre-reset", 16'd4, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_out("async reset", 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step_n(1);
    pulse_start();
    check_out("zero cfg k0", 16'h0000, 1'b1, 1'b0);
    step_n(1);
    check_out("zero cfg k1", 16'h0000, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
